// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (pixel divider, h/v counters,
// active-low syncs, visible-area flag, frame-start strobe).
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame
// counter output (frame_count) that advances on every frame_start.
// All outputs are registered; sync/active/frame flags are computed from the
// next-state counter values so they change on the same edge as the counters.

module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pixel_tick,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0]    V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0]    HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0]    HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0]    VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0]    VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             tick_next;
  logic [CW-1:0]    h_next;
  logic [CW-1:0]    v_next;
  logic             wrap_frame;

  // Divider and raster counter next-state; counters move only on a pixel tick
  always_comb begin
    div_next   = div_cnt + DIV_W'(1);
    tick_next  = 1'b0;
    h_next     = h_counter;
    v_next     = v_counter;
    wrap_frame = 1'b0;

    if (div_cnt == DIV_LAST) begin
      div_next  = '0;
      tick_next = 1'b1;
    end

    if (pixel_tick) begin
      if (h_counter == H_LAST) begin
        h_next = '0;
        if (v_counter == V_LAST) begin
          v_next     = '0;
          wrap_frame = 1'b1;
        end else begin
          v_next = v_counter + CW'(1);
        end
      end else begin
        h_next = h_counter + CW'(1);
      end
    end
  end

  // Timing registers; flags derive from next-state counters for zero skew
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      pixel_tick  <= 1'b0;
      h_counter   <= '0;
      v_counter   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      pixel_tick  <= tick_next;
      h_counter   <= h_next;
      v_counter   <= v_next;
      hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
      vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
      active      <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start <= wrap_frame;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Free-running frame counter for blink/animation effects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (wrap_frame) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. One instance uses the
// default 640x480 timing (CLK_DIV=2) for line-level checks; a second, small
// raster (30x20, CLK_DIV=1) exercises vsync, frame wrap and mid-frame reset
// within a short run.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_d_n;
  logic rst_s_n;

  logic       d_tick, d_hs, d_vs, d_act, d_fs;
  logic [9:0] d_h, d_v;
  logic       s_tick, s_hs, s_vs, s_act, s_fs;
  logic [9:0] s_h, s_v;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] d_fc, s_fc;
  logic [7:0] fc0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk        (clk),
    .reset_n    (rst_d_n),
    .pixel_tick (d_tick),
    .h_counter  (d_h),
    .v_counter  (d_v),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .active     (d_act),
    .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(d_fc)
`endif
  );

  // Small raster: H 16+4+6+4=30 (hsync low 20..25), V 12+2+3+3=20 (vsync low 14..16)
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3)
  ) dut_s (
    .clk        (clk),
    .reset_n    (rst_s_n),
    .pixel_tick (s_tick),
    .h_counter  (s_h),
    .v_counter  (s_v),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .active     (s_act),
    .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(s_fc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hv(input bit sel, input logic [9:0] h, input logic [9:0] v,
                         input int budget, input string tag);
    int  n;
    bit  hit;
    logic [9:0] ch, cv;
    n   = 0;
    hit = 1'b0;
    while (n < budget) begin
      ch = sel ? s_h : d_h;
      cv = sel ? s_v : d_v;
      if (ch == h && cv == v) begin
        hit = 1'b1;
        break;
      end
      step(1);
      n++;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int n;
    int lows;
    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    step(3);

    // Reset values
    chk("rst_tick", 32'(d_tick), 32'd0);
    chk("rst_h", 32'(d_h), 32'd0);
    chk("rst_v", 32'(d_v), 32'd0);
    chk("rst_hs", 32'(d_hs), 32'd1);
    chk("rst_vs", 32'(d_vs), 32'd1);
    chk("rst_act", 32'(d_act), 32'd1);
    chk("rst_fs", 32'(d_fs), 32'd0);

    // Release: tick after the second edge, h=1 after the third
    rst_d_n = 1'b1;
    step(1);
    chk("e1_tick", 32'(d_tick), 32'd0);
    chk("e1_h", 32'(d_h), 32'd0);
    chk("e1_fs", 32'(d_fs), 32'd0);
    step(1);
    chk("e2_tick", 32'(d_tick), 32'd1);
    chk("e2_h", 32'(d_h), 32'd0);
    step(1);
    chk("e3_tick", 32'(d_tick), 32'd0);
    chk("e3_h", 32'(d_h), 32'd1);
    chk("e3_fs", 32'(d_fs), 32'd0);

    // Active boundary on line 0
    wait_hv(1'b0, 10'd639, 10'd0, 4000, "reach_h639");
    chk("h639_act", 32'(d_act), 32'd1);
    chk("h639_hs", 32'(d_hs), 32'd1);
    step(1);
    chk("h639_hold", 32'(d_h), 32'd639);
    step(1);
    chk("h640_h", 32'(d_h), 32'd640);
    chk("h640_act", 32'(d_act), 32'd0);

    // hsync low for h=656..751 = 96 ticks = 192 clocks
    wait_hv(1'b0, 10'd655, 10'd0, 200, "reach_h655");
    chk("h655_hs", 32'(d_hs), 32'd1);
    step(2);
    chk("h656_hs", 32'(d_hs), 32'd0);
    n = 0;
    while (d_hs == 1'b0 && n < 1000) begin
      step(1);
      n++;
    end
    chk("hs_low_clks", 32'(n), 32'd192);
    chk("hs_rise_h", 32'(d_h), 32'd752);

    // Line wrap 799->0 with v 0->1 on the same edge
    wait_hv(1'b0, 10'd799, 10'd0, 400, "reach_h799");
    chk("h799_act", 32'(d_act), 32'd0);
    step(2);
    chk("wrap_h", 32'(d_h), 32'd0);
    chk("wrap_v", 32'(d_v), 32'd1);
    chk("wrap_act", 32'(d_act), 32'd1);
    chk("wrap_fs", 32'(d_fs), 32'd0);

    // Small raster, CLK_DIV=1: tick constant after release
    rst_s_n = 1'b1;
    step(1);
    chk("s_e1_tick", 32'(s_tick), 32'd1);
    chk("s_e1_h", 32'(s_h), 32'd0);
    step(1);
    chk("s_e2_h", 32'(s_h), 32'd1);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_tick !== 1'b1) lows++;
      step(1);
    end
    chk("s_tick_const", 32'(lows), 32'd0);

    // vsync low for whole lines 14..16 (3 lines * 30 clocks)
    wait_hv(1'b1, 10'd29, 10'd13, 1000, "s_reach_29_13");
    chk("s_v13_vs", 32'(s_vs), 32'd1);
    chk("s_v13_act", 32'(s_act), 32'd0);
    step(1);
    chk("s_v14_v", 32'(s_v), 32'd14);
    chk("s_v14_vs", 32'(s_vs), 32'd0);
    n = 0;
    while (s_vs == 1'b0 && n < 1000) begin
      step(1);
      n++;
    end
    chk("s_vs_low_clks", 32'(n), 32'd90);
    chk("s_vs_rise_v", 32'(s_v), 32'd17);
    chk("s_vs_rise_h", 32'(s_h), 32'd0);

    // Active boundaries across the next frame
    wait_hv(1'b1, 10'd15, 10'd11, 1000, "s_reach_15_11");
    chk("s_15_11_act", 32'(s_act), 32'd1);
    step(1);
    chk("s_16_11_act", 32'(s_act), 32'd0);
    wait_hv(1'b1, 10'd0, 10'd12, 100, "s_reach_0_12");
    chk("s_0_12_act", 32'(s_act), 32'd0);

    // frame_start: one clock wide at (0,0), 600 clocks apart
    wait_hv(1'b1, 10'd29, 10'd19, 1000, "s_reach_29_19");
    chk("s_pre_fs", 32'(s_fs), 32'd0);
`ifdef VGA_FRAME_COUNT_EN
    fc0 = s_fc;
    chk("s_fc_before", 32'(fc0), 32'd1);
`endif
    step(1);
    chk("s_fs_h", 32'(s_h), 32'd0);
    chk("s_fs_v", 32'(s_v), 32'd0);
    chk("s_fs_pulse", 32'(s_fs), 32'd1);
`ifdef VGA_FRAME_COUNT_EN
    chk("s_fc_after", 32'(s_fc), 32'd2);
`endif
    step(1);
    chk("s_fs_width", 32'(s_fs), 32'd0);
    n = 1;
    while (s_fs == 1'b0 && n < 2000) begin
      step(1);
      n++;
    end
    chk("s_frame_clks", 32'(n), 32'd600);
    chk("s_frame_hv", 32'({s_h, s_v}), 32'd0);

    // Asynchronous mid-frame reset at h=22, v=15 (inside hsync and vsync)
    wait_hv(1'b1, 10'd22, 10'd15, 1000, "s_reach_22_15");
    chk("s_mid_hs", 32'(s_hs), 32'd0);
    chk("s_mid_vs", 32'(s_vs), 32'd0);
    #3;
    rst_s_n = 1'b0;
    #1;
    chk("s_ar_h", 32'(s_h), 32'd0);
    chk("s_ar_v", 32'(s_v), 32'd0);
    chk("s_ar_hs", 32'(s_hs), 32'd1);
    chk("s_ar_vs", 32'(s_vs), 32'd1);
    chk("s_ar_act", 32'(s_act), 32'd1);
    chk("s_ar_tick", 32'(s_tick), 32'd0);
    rst_s_n = 1'b1;
    step(1);
    chk("s_rel_h", 32'(s_h), 32'd0);
    chk("s_rel_fs", 32'(s_fs), 32'd0);
    step(1);
    chk("s_rel2_h", 32'(s_h), 32'd1);
    chk("s_rel2_v", 32'(s_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
